add_share_sched: RTL and testbench

- Shares one 16-bit carry-lookahead adder slice between NUM_REQ requesters.
- Each request is a 32-bit add, executed as two passes: the low half, then the high half with the carry chained.
- A round-robin arbiter picks the requester and an FSM sequences the slice.
- One result is returned on a valid/ready response channel. The block sits between issuing units and the shared add datapath.

---
 rtl/add_share_pkg.sv | 24 ++
 rtl/add16_slice.sv | 43 ++++
 rtl/add_share_sched.sv | 160 ++++++++++++++++
 tb/tb_add_share_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_share_pkg.sv
// Shared types, widths and the rotating-priority pick used by add_share_sched.
package add_share_pkg;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 16;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  // Returns {found, index}: first set bit of vld scanning upward from last+1, wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] vld,
                                         input logic [2:0]         last,
                                         input int                 n);
    logic [2:0] idx;
    logic [3:0] pick;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((int'(last) + k) % n);
      if (k <= n && !pick[3] && vld[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

endpackage

// File: rtl/add16_slice.sv
// Combinational 16-bit adder: 4-bit groups with group generate/propagate lookahead.
module add16_slice
  import add_share_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int GRP = 4;
  localparam int NG  = SLICE_W / GRP;

  logic [SLICE_W-1:0] g, p, c;
  logic [NG-1:0]      gg, gp;
  logic [NG:0]        gc;

  always_comb begin
    g = a & b;
    p = a ^ b;
    gg = '0;
    gp = '1;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GRP; i++) begin
        gg[j] = g[j*GRP+i] | (p[j*GRP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GRP+i];
      end
    end
    // Group carries come from the lookahead terms, not from the in-group ripple.
    gc[0] = cin;
    for (int j = 0; j < NG; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[j*GRP] = gc[j];
      for (int i = 0; i < GRP-1; i++)
        c[j*GRP+i+1] = g[j*GRP+i] | (p[j*GRP+i] & c[j*GRP+i]);
    end
    sum  = p ^ c;
    cout = gc[NG];
  end

endmodule

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one 16-bit adder slice for 32-bit adds (low half, then high half).
// Optional ADD_SHARE_OVF_EN adds resp_ovf (signed overflow of the 32-bit result).
module add_share_sched
  import add_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_sum,
  output logic                      resp_cout,
`ifdef ADD_SHARE_OVF_EN
  output logic                      resp_ovf,
`endif
  output logic                      busy
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d;
  logic                 cin_q, cin_d;
  logic [SLICE_W-1:0]   sum_lo_q, sum_lo_d, sum_hi_q, sum_hi_d;
  logic                 c16_q, c16_d;
  logic                 cout_q, cout_d;
  logic                 vld_q, vld_d;
`ifdef ADD_SHARE_OVF_EN
  logic                 ovf_q, ovf_d;
`endif

  logic                 gnt_ok;
  logic [2:0]           gnt_idx;
  logic [ID_W-1:0]      gnt_id;
  logic [SLICE_W-1:0]   slice_a, slice_b, slice_sum;
  logic                 slice_cin, slice_cout;

  always_comb begin
    {gnt_ok, gnt_idx} = rr_pick(MAX_REQ'(req_valid), 3'(last_q), NUM_REQ);
    gnt_id = ID_W'(gnt_idx);
  end

  assign slice_a   = (state_q == LO) ? a_q[SLICE_W-1:0] : a_q[DATA_W-1:SLICE_W];
  assign slice_b   = (state_q == LO) ? b_q[SLICE_W-1:0] : b_q[DATA_W-1:SLICE_W];
  assign slice_cin = (state_q == LO) ? cin_q : c16_q;

  add16_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    sum_lo_d = sum_lo_q;
    sum_hi_d = sum_hi_q;
    c16_d    = c16_q;
    cout_d   = cout_q;
    vld_d    = vld_q;
`ifdef ADD_SHARE_OVF_EN
    ovf_d    = ovf_q;
`endif
    req_ready = '0;
    case (state_q)
      IDLE: begin
        // rst_n gate keeps req_ready low while reset is held, not just after it.
        if (gnt_ok && rst_n) begin
          req_ready = NUM_REQ'(1) << gnt_id;
          a_d     = req_a[DATA_W*gnt_id +: DATA_W];
          b_d     = req_b[DATA_W*gnt_id +: DATA_W];
          cin_d   = req_cin[gnt_id];
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = LO;
        end
      end
      LO: begin
        sum_lo_d = slice_sum;
        c16_d    = slice_cout;
        state_d  = HI;
      end
      HI: begin
        sum_hi_d = slice_sum;
        cout_d   = slice_cout;
`ifdef ADD_SHARE_OVF_EN
        // Carry into bit 31 recovered from the sum bit; overflow = c31 ^ c32.
        ovf_d    = (a_q[DATA_W-1] ^ b_q[DATA_W-1] ^ slice_sum[SLICE_W-1]) ^ slice_cout;
`endif
        vld_d    = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_lo_q <= '0;
      sum_hi_q <= '0;
      c16_q    <= 1'b0;
      cout_q   <= 1'b0;
      vld_q    <= 1'b0;
`ifdef ADD_SHARE_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      sum_lo_q <= sum_lo_d;
      sum_hi_q <= sum_hi_d;
      c16_q    <= c16_d;
      cout_q   <= cout_d;
      vld_q    <= vld_d;
`ifdef ADD_SHARE_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign resp_valid = vld_q;
  assign resp_id    = id_q;
  assign resp_sum   = {sum_hi_q, sum_lo_q};
  assign resp_cout  = cout_q;
  assign busy       = (state_q != IDLE);
`ifdef ADD_SHARE_OVF_EN
  assign resp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_share_sched.sv
// Directed + random bench for add_share_sched against a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_add_share_sched;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, req_cin;
  logic [N*32-1:0]  req_a, req_b;
  logic             resp_valid, resp_ready, resp_cout, busy;
  logic [IDW-1:0]   resp_id;
  logic [31:0]      resp_sum;
`ifdef ADD_SHARE_OVF_EN
  logic             resp_ovf;
`endif

  logic [31:0] ta [N];
  logic [31:0] tb_ [N];
  int total = 0;
  int bad   = 0;
  int last_m;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_a[32*i +: 32] = ta[i];
    assign req_b[32*i +: 32] = tb_[i];
  end

  add_share_sched #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
`ifdef ADD_SHARE_OVF_EN
    .resp_ovf   (resp_ovf),
`endif
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rotating priority: first valid requester after the last one granted.
  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_m + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_cin    = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin ta[i] = '0; tb_[i] = '0; end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    last_m = N - 1;
  endtask

  // Called at a negedge with the DUT idle and inputs set up; runs one full transaction.
  task automatic one_txn(input int stall, input bit keep, output int gid);
    int g;
    logic [32:0] e;
    logic [31:0] ea, eb;
    logic eovf;
    g = model_pick();
    gid = g;
    #1;
    chk("req_ready_grant", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("busy_idle", 64'(busy), 64'd0);
    if (g < 0) begin
      @(negedge clk);
      return;
    end
    ea   = ta[g];
    eb   = tb_[g];
    e    = {1'b0, ea} + {1'b0, eb} + 33'(req_cin[g]);
    eovf = (ea[31] == eb[31]) && (e[31] != ea[31]);
    @(posedge clk);
    #1;
    last_m = g;
    if (keep) begin
      ta[g] = pick_op(); tb_[g] = pick_op(); req_cin[g] = 1'($urandom);
    end else begin
      req_valid[g] = 1'b0;
    end
    // Requesters that are not asking may change operands freely.
    for (int i = 0; i < N; i++)
      if (!req_valid[i]) begin ta[i] = $urandom; tb_[i] = $urandom; end
    @(negedge clk);
    chk("lo_valid", 64'(resp_valid), 64'd0);
    chk("lo_busy", 64'(busy), 64'd1);
    chk("lo_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("hi_valid", 64'(resp_valid), 64'd0);
    chk("hi_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      resp_ready = (s == stall);
      chk("done_valid", 64'(resp_valid), 64'd1);
      chk("done_sum", 64'(resp_sum), 64'(e[31:0]));
      chk("done_cout", 64'(resp_cout), 64'(e[32]));
      chk("done_id", 64'(resp_id), 64'(g));
      chk("done_ready", 64'(req_ready), 64'd0);
      chk("done_busy", 64'(busy), 64'd1);
`ifdef ADD_SHARE_OVF_EN
      chk("done_ovf", 64'(resp_ovf), 64'(eovf));
`endif
      if (s < stall) @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", 64'(resp_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid;
    logic [N-1:0] newv;

    do_reset();
    #1;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    chk("rst_sum", 64'(resp_sum), 64'd0);
    chk("rst_cout", 64'(resp_cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
`ifdef ADD_SHARE_OVF_EN
    chk("rst_ovf", 64'(resp_ovf), 64'd0);
`endif
    @(negedge clk);

    // Carry across the half boundary, full carry out, signed overflow corners.
    ta[0] = 32'h0000_FFFF; tb_[0] = 32'h1; req_cin[0] = 1'b0; req_valid = 4'b0001;
    one_txn(0, 1'b0, gid);
    chk("single_id", 64'(gid), 64'd0);
    ta[0] = 32'hFFFF_FFFF; tb_[0] = 32'h0; req_cin[0] = 1'b1; req_valid = 4'b0001;
    one_txn(0, 1'b0, gid);
    ta[0] = 32'h7FFF_FFFF; tb_[0] = 32'h1; req_cin[0] = 1'b0; req_valid = 4'b0001;
    one_txn(0, 1'b0, gid);
    ta[0] = 32'hFFFF_FFFF; tb_[0] = 32'h1; req_cin[0] = 1'b0; req_valid = 4'b0001;
    one_txn(0, 1'b0, gid);

    // All requesters held valid: grant order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      ta[i] = 32'h1000_0000 * (i + 1) + 32'h0000_F00F; tb_[i] = 32'h0001_1111 * (i + 3); req_cin[i] = 1'(i);
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      one_txn(0, 1'b1, gid);
      chk("rr_order", 64'(gid), 64'(k % N));
    end

    // Backpressure: five stalled cycles in DONE.
    one_txn(5, 1'b1, gid);

    // Reset while in HI discards the request and restarts priority at 0.
    do_reset();
    ta[2] = 32'h1234_5678; tb_[2] = 32'h1111_1111; req_valid = 4'b0100;
    #1;
    chk("mid_grant", 64'(req_ready), 64'd4);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sum", 64'(resp_sum), 64'd0);
    chk("mid_rst_id", 64'(resp_id), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = N - 1;
    chk("mid_no_stale", 64'(resp_valid), 64'd0);
    one_txn(0, 1'b1, gid);
    chk("mid_prio0", 64'(gid), 64'd0);

    // Random traffic; valid requesters keep their operands until granted.
    do_reset();
    for (int t = 0; t < 10000; t++) begin
      newv = N'($urandom) & ~req_valid;
      for (int i = 0; i < N; i++)
        if (newv[i]) begin ta[i] = pick_op(); tb_[i] = pick_op(); req_cin[i] = 1'($urandom); end
      req_valid = req_valid | newv;
      one_txn(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0, 1'($urandom), gid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
